icache_refill_arbiter: RTL
==========================

Name: icache_refill_arbiter

Overview:
- Shares the single downstream memory read port between N instruction-cache miss requesters.
- Round-robin fair grant; one refill transaction outstanding at a time.
- Routes the BEATS-beat line refill response back to the owning requester.
- Sits between the icache miss handlers and the L2/memory interface.

Parameters:
N, 4, number of miss requesters (≥2)
ADDR_W, 32, line address width
DATA_W, 64, refill beat data width
BEATS, 4, beats per cache line refill (≥1)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  N  per-requester miss request valid
req_addr  input  N*ADDR_W  per-requester line address, requester i at [i*ADDR_W +: ADDR_W]
req_ready  output  N  one-hot request accept
mem_req_valid  output  1  downstream read request valid
mem_req_ready  input  1  downstream read request accept
mem_req_addr  output  ADDR_W  downstream read address
mem_rsp_valid  input  1  refill beat valid (no backpressure)
mem_rsp_data  input  DATA_W  refill beat data
rsp_valid  output  N  one-hot beat valid to owner
rsp_data  output  DATA_W  beat data, broadcast to all requesters
rsp_last  output  1  final beat of line
busy  output  1  transaction in flight (state ≠ IDLE)
grant_id  output  $clog2(N)  index of current owner
protocol_err  output  1  sticky; beat received outside WAIT_RESP

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0 (port 0 highest priority), beat count=0, owner=0, addr register=0, protocol_err=0. All outputs 0.
- FSM has three states: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If any req_valid, select winner: first requester with req_valid found searching from pointer upward, wrapping at N-1→0.
  - req_ready[winner]=1 combinationally in the same cycle; the handshake completes then.
  - On that edge: latch owner and req_addr[winner]; pointer ← (winner+1) mod N; go to ISSUE.
  - req_ready is 0 in all other states and for all non-winners.
  - No request: stay in IDLE; pointer holds.
- ISSUE:
  - mem_req_valid=1; mem_req_addr=latched addr, stable until accepted.
  - On mem_req_ready=1 → WAIT_RESP, beat count=0.
  - Stall indefinitely while mem_req_ready=0.
- WAIT_RESP:
  - rsp_valid[owner]=mem_rsp_valid and rsp_data=mem_rsp_data combinationally (zero latency).
  - Beat count increments per valid beat.
  - rsp_last=1 on the beat where count==BEATS-1; that beat returns the FSM to IDLE.
  - Beats may be non-consecutive (gaps allowed).
- Minimum spacing between successive grants: IDLE→ISSUE→WAIT_RESP→IDLE. A new grant is possible in the cycle after the last beat.
- mem_rsp_valid in IDLE or ISSUE: beat dropped, rsp_valid stays 0, protocol_err set (sticky until reset).
- Requester changing req_valid while not granted: allowed; arbitration uses only the IDLE-cycle values.
- busy=1 in ISSUE and WAIT_RESP.
- grant_id = latched owner, valid while busy; in IDLE it shows the last owner.
- Reset mid-transaction: immediate return to IDLE. Partial refill is abandoned with no further rsp_valid; the pointer returns to 0.
- BEATS=1: rsp_last on every response beat.
- Beat counter width is $clog2(BEATS) with minimum 1; it never wraps because it returns to 0 on the last beat.

Test Plan:
- Single request, all ready: req_valid=4'b0100, addr 0x1000, mem_req_ready=1, beats D0..D3 → req_ready=4'b0100 in cycle 0; mem_req_valid with 0x1000 in cycle 1; rsp_valid=4'b0100 on each beat; rsp_last only with D3; busy drops the next cycle.
- Fairness: all four req_valid held high for four transactions → grant order 0,1,2,3, then 0 again; each grant after the previous last beat.
- Wrap and skip: pointer=3, req_valid=4'b0011 → port 0 granted, pointer becomes 1; next grant with 4'b0011 → port 1.
- Downstream stall: mem_req_ready held 0 for 5 cycles in ISSUE → mem_req_valid and addr stable for 6 cycles; no req_ready asserted; transition on the accept cycle.
- Gapped beats and spurious beat: beats separated by 2 idle cycles → rsp_valid only on valid cycles, count correct. A mem_rsp_valid pulse in IDLE → no rsp_valid, protocol_err=1 and stays 1.
- Reset mid-refill: assert rst after beat 2 of 4 → outputs 0 immediately. Following request from port 2 with 4'b0110 pending → port 1 granted, since the pointer was reset to 0.

Source files
------------

// File: rtl/icache_refill_arbiter_if.sv
// Bundle of the requester-side and memory-side signals of the icache refill arbiter.
// The slave modport is the arbiter; the master modport is the environment around it.
interface icache_refill_arbiter_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]        req_valid;
    logic [N*ADDR_W-1:0] req_addr;
    logic [N-1:0]        req_ready;
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [ADDR_W-1:0]   mem_req_addr;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;
    logic [N-1:0]        rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_last;
    logic                busy;
    logic [ID_W-1:0]     grant_id;
    logic                protocol_err;

    modport slave (
        input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data,
               rsp_last, busy, grant_id, protocol_err
    );

    modport master (
        output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data,
               rsp_last, busy, grant_id, protocol_err
    );
endinterface

// File: rtl/icache_refill_arbiter.sv
// Round-robin arbiter sharing one memory read port among N icache miss handlers,
// with one line refill outstanding and beats routed back to the owning requester.
module icache_refill_arbiter #(
    parameter int N      = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BEATS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    icache_refill_arbiter_if.slave  io_bus,
    output logic [1:0]              o_dbg_state
);
    localparam int ID_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // Handshakes: a request transfers on req_valid & req_ready, a memory read on
    // mem_req_valid & mem_req_ready; response beats have no backpressure.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_owner;
    logic [ADDR_W-1:0]  r_addr;
    logic [CNT_W-1:0]   r_beat;
    logic               r_perr;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic               w_last;

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && io_bus.req_valid[(int'(r_ptr) + k) % N]) begin
                w_found  = 1'b1;
                w_winner = ID_W'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_last = (r_state == S_WAIT) && io_bus.mem_rsp_valid &&
                    (r_beat == CNT_W'(BEATS - 1));

    always_comb begin
        w_next               = r_state;
        io_bus.req_ready     = '0;
        io_bus.mem_req_valid = 1'b0;
        io_bus.rsp_valid     = '0;
        io_bus.rsp_data      = '0;
        io_bus.rsp_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    io_bus.req_ready[w_winner] = 1'b1;
                    w_next                     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                io_bus.mem_req_valid = 1'b1;
                if (io_bus.mem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                io_bus.rsp_data            = io_bus.mem_rsp_data;
                io_bus.rsp_valid[r_owner]  = io_bus.mem_rsp_valid;
                io_bus.rsp_last            = w_last;
                if (w_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_addr  <= '0;
            r_beat  <= '0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_found) begin
                r_owner <= w_winner;
                r_addr  <= io_bus.req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
                r_ptr   <= (w_winner == ID_W'(N - 1)) ? '0 : w_winner + ID_W'(1);
            end
            if (r_state == S_ISSUE && io_bus.mem_req_ready) r_beat <= '0;
            if (r_state == S_WAIT && io_bus.mem_rsp_valid)
                r_beat <= w_last ? '0 : r_beat + CNT_W'(1);
            // A beat arriving with no refill awaiting it is a downstream protocol bug.
            if (io_bus.mem_rsp_valid && r_state != S_WAIT) r_perr <= 1'b1;
        end
    end

    assign io_bus.mem_req_addr = r_addr;
    assign io_bus.busy         = (r_state != S_IDLE);
    assign io_bus.grant_id     = r_owner;
    assign io_bus.protocol_err = r_perr;
    assign o_dbg_state         = r_state;
endmodule
